// File: rtl/rf_scoreboard_if.sv
// rf_scoreboard_if: ID-stage hazard query, issue and
// long-latency writeback bundle for the register scoreboard.
interface rf_scoreboard_if #(
   parameter int CNT_W = 3
);
   logic             id_valid_i;
   logic [4:0]       id_rs1_i;
   logic             id_rs1_used_i;
   logic [4:0]       id_rs2_i;
   logic             id_rs2_used_i;
   logic [4:0]       id_rd_i;
   logic             id_rf_en_i;
   logic             id_long_lat_i;
   logic             issue_i;
   logic             flush_i;
   logic             wb_valid_i;
   logic [4:0]       wb_rd_i;
   logic             stall_o;
   logic [31:0]      busy_o;
   logic [CNT_W-1:0] outstanding_o;
   logic             full_o;
   logic             err_o;
   logic [31:0]      stall_cycles_o;

   modport master (
      output id_valid_i, id_rs1_i, id_rs1_used_i,
      output id_rs2_i, id_rs2_used_i,
      output id_rd_i, id_rf_en_i, id_long_lat_i,
      output issue_i, flush_i, wb_valid_i, wb_rd_i,
      input  stall_o, busy_o, outstanding_o,
      input  full_o, err_o, stall_cycles_o
   );

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs1_used_i,
      input  id_rs2_i, id_rs2_used_i,
      input  id_rd_i, id_rf_en_i, id_long_lat_i,
      input  issue_i, flush_i, wb_valid_i, wb_rd_i,
      output stall_o, busy_o, outstanding_o,
      output full_o, err_o, stall_cycles_o
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bits for long-latency producers,
// RAW/WAW/capacity stall for ID, and outstanding count.
module rf_scoreboard #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input logic           clk,
   input logic           arst_n,
   rf_scoreboard_if.slave sb
);

   logic [31:0]      busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic [31:0]      stall_cnt_q;

   logic [31:0] clr_vec;
   logic [31:0] set_vec;
   logic [31:0] eff_busy;
   logic        wb_hit;
   logic        wb_bad;
   logic        rd_nz;
   logic        full;
   logic        raw1;
   logic        raw2;
   logic        waw;
   logic        cap;
   logic        stall;
   logic        set_en;
   logic        bad_issue;

   assign full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign rd_nz = (sb.id_rd_i != 5'd0);

   // Writeback match; busy[0] is never set, so x0 never hits.
   always_comb begin
      clr_vec = '0;
      wb_hit  = sb.wb_valid_i & busy_q[sb.wb_rd_i];
      wb_bad  = sb.wb_valid_i & ~wb_hit;
      if (wb_hit) clr_vec[sb.wb_rd_i] = 1'b1;
      eff_busy = busy_q & ~clr_vec;
   end

   // Hazards see writebacks of this cycle as already done.
   always_comb begin
      raw1 = sb.id_rs1_used_i & eff_busy[sb.id_rs1_i];
      raw2 = sb.id_rs2_used_i & eff_busy[sb.id_rs2_i];
      waw  = sb.id_rf_en_i & eff_busy[sb.id_rd_i];
      cap  = sb.id_long_lat_i & sb.id_rf_en_i & rd_nz
           & full & ~wb_hit;
      stall = sb.id_valid_i & ~sb.flush_i
            & (raw1 | raw2 | waw | cap);
      bad_issue = sb.issue_i & stall;
      set_en = sb.issue_i & sb.id_valid_i & ~sb.flush_i
             & ~stall & sb.id_rf_en_i
             & sb.id_long_lat_i & rd_nz;
      set_vec = '0;
      if (set_en) set_vec[sb.id_rd_i] = 1'b1;
   end

   // Busy bits: set wins over a same-register clear.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= ((busy_q & ~clr_vec) | set_vec)
                 & ~32'h1;
      end
   end

   // Outstanding count: set and clear together cancel.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q <= '0;
      end else begin
         case ({set_en, wb_hit})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Sticky protocol error.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_q <= 1'b0;
      end else if (wb_bad | bad_issue) begin
         err_q <= 1'b1;
      end
   end

   // Saturating stall cycle counter.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign sb.stall_o        = stall;
   assign sb.busy_o         = busy_q;
   assign sb.outstanding_o  = cnt_q;
   assign sb.full_o         = full;
   assign sb.err_o          = err_q;
   assign sb.stall_cycles_o = stall_cnt_q;

endmodule
